// File: rtl/key_event_arbiter.sv
// Turns debounced key stable-state reports into press/release/long-press events.
// Events share one valid/ready channel through round-robin arbitration between keys.
module key_event_arbiter #(
  parameter int unsigned NUM_KEYS    = 2,
  parameter int unsigned LONG_CYCLES = 25_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_flag,
  input  logic [NUM_KEYS-1:0] key_value,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [1:0]          evt_key,
  output logic [1:0]          evt_type,
  output logic [NUM_KEYS-1:0] held,
  output logic                evt_drop
);

  localparam int unsigned CW = (LONG_CYCLES > 2) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(LONG_CYCLES - 2);

  localparam logic [1:0] EVT_PRESS = 2'b00;
  localparam logic [1:0] EVT_REL   = 2'b01;
  localparam logic [1:0] EVT_LONG  = 2'b10;

  logic [NUM_KEYS-1:0] p_press, p_rel, p_long;
  logic [NUM_KEYS-1:0] p_press_n, p_rel_n, p_long_n, held_n;
  logic [CW-1:0]       cnt   [NUM_KEYS];
  logic [CW-1:0]       cnt_n [NUM_KEYS];
  logic [1:0]          rr_ptr, rr_n;
  logic                valid_n, drop_n;
  logic [1:0]          key_n, type_n;

  logic [3:0]          elig4, press4, long4;
  logic [2:0]          cand;
  logic [1:0]          gnt_idx, gnt_type;
  logic                gnt_found, do_grant;
  logic [NUM_KEYS-1:0] gnt_mask, clr_press, clr_rel, clr_long;
  logic [NUM_KEYS-1:0] set_press, set_rel, set_long;

  // Round-robin key selection and in-key event priority: press > long > release.
  always_comb begin : arbitrate
    elig4     = 4'(p_press | p_long | p_rel);
    press4    = 4'(p_press);
    long4     = 4'(p_long);
    gnt_found = 1'b0;
    gnt_idx   = 2'd0;
    cand      = 3'd0;
    for (int off = 0; off < int'(NUM_KEYS); off++) begin
      cand = {1'b0, rr_ptr} + 3'(off);
      if (cand >= 3'(NUM_KEYS)) cand = cand - 3'(NUM_KEYS);
      if (!gnt_found && elig4[cand[1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[1:0];
      end
    end
    do_grant = gnt_found && (!evt_valid || evt_ready);
    if (press4[gnt_idx])     gnt_type = EVT_PRESS;
    else if (long4[gnt_idx]) gnt_type = EVT_LONG;
    else                     gnt_type = EVT_REL;
    gnt_mask  = do_grant ? NUM_KEYS'(4'b0001 << gnt_idx) : '0;
    clr_press = (gnt_type == EVT_PRESS) ? gnt_mask : '0;
    clr_long  = (gnt_type == EVT_LONG)  ? gnt_mask : '0;
    clr_rel   = (gnt_type == EVT_REL)   ? gnt_mask : '0;
    rr_n = rr_ptr;
    if (do_grant) begin
      if (3'(gnt_idx) + 3'd1 >= 3'(NUM_KEYS)) rr_n = 2'd0;
      else                                    rr_n = gnt_idx + 2'd1;
    end
  end

  // Edge decode, hold counters, pending slots and drop detection.
  always_comb begin : key_update
    set_press = key_flag & ~key_value & ~held;
    set_rel   = key_flag & key_value & held;
    set_long  = '0;
    cnt_n     = cnt;
    for (int i = 0; i < int'(NUM_KEYS); i++) begin
      set_long[i] = held[i] && !set_rel[i] && (cnt[i] == CNT_PRE);
      if (set_press[i] || set_rel[i])        cnt_n[i] = '0;
      else if (held[i] && cnt[i] != CNT_LAST) cnt_n[i] = cnt[i] + CW'(1);
    end
    held_n    = (held | set_press) & ~set_rel;
    p_press_n = (p_press & ~clr_press) | set_press;
    p_rel_n   = (p_rel & ~clr_rel) | set_rel;
    p_long_n  = (p_long & ~clr_long) | set_long;
    drop_n    = |((set_press & p_press & ~clr_press) |
                  (set_rel & p_rel & ~clr_rel) |
                  (set_long & p_long & ~clr_long));
  end

  // Output register: load on grant, hold under backpressure, empty on accept.
  always_comb begin : out_next
    valid_n = evt_valid;
    key_n   = evt_key;
    type_n  = evt_type;
    if (do_grant) begin
      valid_n = 1'b1;
      key_n   = gnt_idx;
      type_n  = gnt_type;
    end else if (evt_ready) begin
      valid_n = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_press   <= '0;
      p_rel     <= '0;
      p_long    <= '0;
      held      <= '0;
      rr_ptr    <= 2'd0;
      evt_valid <= 1'b0;
      evt_key   <= 2'd0;
      evt_type  <= 2'd0;
      evt_drop  <= 1'b0;
      for (int i = 0; i < int'(NUM_KEYS); i++) cnt[i] <= '0;
    end else begin
      p_press   <= p_press_n;
      p_rel     <= p_rel_n;
      p_long    <= p_long_n;
      held      <= held_n;
      rr_ptr    <= rr_n;
      evt_valid <= valid_n;
      evt_key   <= key_n;
      evt_type  <= type_n;
      evt_drop  <= drop_n;
      for (int i = 0; i < int'(NUM_KEYS); i++) cnt[i] <= cnt_n[i];
    end
  end

endmodule
